ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, consuming operands, funct3 and an M-op strobe from the decode/execute pipeline register. It computes all eight M-extension operations with a shared 32-cycle shift-add/restoring-divide datapath. While an operation is in progress it raises a stall to the hazard unit, which holds the instruction in EX. It delivers the result in the cycle the stall drops, so the instruction advances with a valid result.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/ex_muldiv.sv | 117 +++++++++++
 tb/tb_ex_muldiv.sv | 116 +++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the iterative RV32M unit
package muldiv_pkg;
  localparam int ITER_COUNT = 32;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: 32-cycle shift-add / restoring-divide RV32M unit that stalls EX until its result is ready
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_e_i,
  input  logic [2:0]            funct3_e_i,
  input  logic [DATA_WIDTH-1:0] src_a_e_i,
  input  logic [DATA_WIDTH-1:0] src_b_e_i,
  input  logic                  flush_e_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic neg_q, neg_d, negr_q, negr_d;
  logic [2*W-1:0] acc_q, acc_d, step;
  logic [W-1:0] opb_q, opb_d, result_q, result_d;
  logic sa, sb, is_div, b_zero, ovf;
  logic [W:0] mul_sum, div_top, div_diff;
  function automatic logic [W-1:0] neg_if(input logic n, input logic [W-1:0] v);
    return n ? -v : v;
  endfunction
  function automatic logic [W-1:0] finalize(input logic [2:0] op, input logic n, input logic nr,
                                            input logic [2*W-1:0] acc);
    logic [2*W-1:0] prod;
    prod = n ? -acc : acc;
    if (!op[2]) return (op == F3_MUL) ? prod[W-1:0] : prod[2*W-1:W];
    return op[1] ? neg_if(nr, acc[2*W-1:W]) : neg_if(n, acc[W-1:0]);
  endfunction
  // Operand signedness: a is signed except for the unsigned ops; b only for MUL/MULH/DIV/REM
  assign sa     = src_a_e_i[W-1] & ~(funct3_e_i == F3_MULHU || funct3_e_i == F3_DIVU || funct3_e_i == F3_REMU);
  assign sb     = src_b_e_i[W-1] & (funct3_e_i == F3_MUL || funct3_e_i == F3_MULH ||
                                    funct3_e_i == F3_DIV || funct3_e_i == F3_REM);
  assign is_div = funct3_e_i[2];
  assign b_zero = src_b_e_i == '0;
  assign ovf    = ~funct3_e_i[0] & (src_a_e_i == MIN_NEG) & (src_b_e_i == '1);
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_top  = acc_q[2*W-1:W-1];
  assign div_diff = div_top - {1'b0, opb_q};
  // Restoring divide keeps the partial remainder in the high word and shifts quotient bits into the low word
  assign step = op_q[2]
    ? (div_diff[W] ? {div_top[W-1:0], acc_q[W-2:0], 1'b0} : {div_diff[W-1:0], acc_q[W-2:0], 1'b1})
    : {mul_sum, acc_q[W-1:1]};
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: if (start_e_i) begin
        op_d    = funct3_e_i;
        neg_d   = sa ^ sb;
        negr_d  = sa;
        opb_d   = neg_if(sb, src_b_e_i);
        acc_d   = {{W{1'b0}}, neg_if(sa, src_a_e_i)};
        cnt_d   = '0;
        state_d = CALC;
        if (is_div && b_zero) begin
          state_d  = DONE;
          result_d = funct3_e_i[1] ? src_a_e_i : '1;
        end else if (is_div && ovf) begin
          state_d  = DONE;
          result_d = funct3_e_i[1] ? '0 : MIN_NEG;
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER_COUNT - 1)) begin
          state_d  = DONE;
          result_d = finalize(op_q, neg_q, negr_q, step);
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_e_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end
  assign stall_o  = (state_q == IDLE && start_e_i && !flush_e_i) || state_q == CALC;
  assign done_o   = state_q == DONE;
  assign result_o = result_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of the RV32M unit's results, stall timing, flush and async reset
module tb_ex_muldiv;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] f3 = '0;
  logic [31:0] a = '0, b = '0;
  logic stall, done;
  logic [31:0] result;
  int tests = 0, fails = 0;
  ex_muldiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_e_i(start), .funct3_e_i(f3),
    .src_a_e_i(a), .src_b_e_i(b), .flush_e_i(flush),
    .stall_o(stall), .done_o(done), .result_o(result)
  );
  always #5 clk = ~clk;
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       output int cyc, output logic dn, output logic [31:0] res);
    @(negedge clk);
    f3 = op; a = x; b = y; start = 1'b1; cyc = 0;
    #1;
    while (stall && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    dn = done; res = result; start = 1'b0;
  endtask
  task automatic test_reset();
    #3;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk); rst_n = 1'b1;
  endtask
  task automatic test_mul();
    int c; logic d; logic [31:0] r;
    issue(3'b000, 32'd7, 32'hFFFFFFFD, c, d, r);
    tests++; if (c !== 33) begin fails++; $display("FAIL mul_stall_cycles got %0d want 33", c); end
    tests++; if (d !== 1'b1) begin fails++; $display("FAIL mul_done got %b want 1", d); end
    tests++; if (r !== 32'hFFFFFFEB) begin fails++; $display("FAIL mul_result got %h want ffffffeb", r); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL mul_after done=%b stall=%b want 0 0", done, stall); end
  endtask
  task automatic test_mulh();
    int c; logic d; logic [31:0] r;
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, c, d, r);
    tests++; if (r !== 32'hFFFFFFFE || !d) begin fails++; $display("FAIL mulhu got %h done=%b want fffffffe", r, d); end
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, c, d, r);
    tests++; if (r !== 32'h0 || !d) begin fails++; $display("FAIL mulh got %h done=%b want 00000000", r, d); end
    issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, c, d, r);
    tests++; if (r !== 32'hFFFFFFFF || !d) begin fails++; $display("FAIL mulhsu got %h done=%b want ffffffff", r, d); end
  endtask
  task automatic test_div();
    int c; logic d; logic [31:0] r;
    issue(3'b100, 32'hFFFFFFF9, 32'd2, c, d, r);
    tests++; if (r !== 32'hFFFFFFFD || c !== 33) begin fails++; $display("FAIL div got %h cyc=%0d want fffffffd 33", r, c); end
    issue(3'b110, 32'hFFFFFFF9, 32'd2, c, d, r);
    tests++; if (r !== 32'hFFFFFFFF || !d) begin fails++; $display("FAIL rem got %h want ffffffff", r); end
    issue(3'b111, 32'd7, 32'd2, c, d, r);
    tests++; if (r !== 32'd1 || !d) begin fails++; $display("FAIL remu got %h want 00000001", r); end
  endtask
  task automatic test_special();
    int c; logic d; logic [31:0] r;
    issue(3'b101, 32'd5, 32'd0, c, d, r);
    tests++; if (r !== 32'hFFFFFFFF || c !== 1 || !d) begin fails++; $display("FAIL divu_by0 got %h cyc=%0d want ffffffff 1", r, c); end
    issue(3'b111, 32'd5, 32'd0, c, d, r);
    tests++; if (r !== 32'd5 || c !== 1 || !d) begin fails++; $display("FAIL remu_by0 got %h cyc=%0d want 00000005 1", r, c); end
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, c, d, r);
    tests++; if (r !== 32'h80000000 || c !== 1 || !d) begin fails++; $display("FAIL div_ovf got %h cyc=%0d want 80000000 1", r, c); end
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, c, d, r);
    tests++; if (r !== 32'h0 || c !== 1 || !d) begin fails++; $display("FAIL rem_ovf got %h cyc=%0d want 00000000 1", r, c); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL special_no_retrigger done=%b want 0", done); end
  endtask
  task automatic test_flush();
    int c; logic d; logic [31:0] r;
    @(negedge clk);
    f3 = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
    repeat (11) @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++; if (stall !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL flush_idle stall=%b done=%b want 0 0", stall, done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL flush_result got %h want 00000000", result); end
    repeat (30) @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL flush_late_done got %b want 0", done); end
    issue(3'b000, 32'd3, 32'd4, c, d, r);
    tests++; if (r !== 32'd12 || c !== 33 || !d) begin fails++; $display("FAIL mul_after_flush got %h cyc=%0d want 0000000c 33", r, c); end
  endtask
  task automatic test_async_reset();
    int c; logic d; logic [31:0] r;
    @(negedge clk);
    f3 = 3'b100; a = 32'd50; b = 32'd3; start = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (stall !== 1'b1 || result !== 32'h0 || done !== 1'b0) begin fails++; $display("FAIL rst_mid stall=%b result=%h done=%b want 1 0 0", stall, result, done); end
    start = 1'b0;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", stall); end
    @(negedge clk); rst_n = 1'b1;
    issue(3'b101, 32'd100, 32'd7, c, d, r);
    tests++; if (r !== 32'd14 || c !== 33 || !d) begin fails++; $display("FAIL divu_after_rst got %h cyc=%0d want 0000000e 33", r, c); end
    issue(3'b111, 32'd100, 32'd7, c, d, r);
    tests++; if (r !== 32'd2 || !d) begin fails++; $display("FAIL remu_after_rst got %h want 00000002", r); end
  endtask
  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
